// File: rtl/cla_seq_addsub16.sv
// Sequential 16-bit adder/subtractor: one 4-bit carry-lookahead nibble per cycle,
// least significant nibble first, with carry/overflow reported on completion.
module cla_seq_addsub16 #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sub,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] sum,
   output logic              cout,
   output logic              ovf
);

   localparam int NIB = DATA_W / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [DATA_W-5:0] acc_r;
   logic              carry_r;
   logic [IW-1:0]     idx_r;

   logic [3:0] nib_s;
   logic       nib_c3;
   logic       nib_co;
   logic       last_nib;

   // Two-level lookahead over one nibble. Returns {carry_out, carry_into_bit3, sum[3:0]}.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic cin);
      logic [3:0] p;
      logic [3:0] g;
      logic       c1, c2, c3;
      logic       gp, gg, co;
      p  = x ^ y;
      g  = x & y;
      c1 = g[0] | (p[0] & cin);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      gp = &p;
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      co = gg | (gp & cin);
      return {co, c3, p ^ {c3, c2, c1, cin}};
   endfunction

   assign {nib_co, nib_c3, nib_s} = cla4(a_r[3:0], b_r[3:0], carry_r);
   assign last_nib = (idx_r == IW'(NIB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = RUN;
         RUN:     if (last_nib) state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Operands shift right a nibble per cycle so the adder always sees bits [3:0];
   // finished nibbles enter acc_r from the top and land in place after the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         acc_r   <= '0;
         carry_r <= 1'b0;
         idx_r   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= sub ? ~b : b;
                  carry_r <= sub;
                  idx_r   <= '0;
               end
            end
            RUN: begin
               a_r     <= a_r >> 4;
               b_r     <= b_r >> 4;
               acc_r   <= {nib_s, acc_r[DATA_W-5:4]};
               carry_r <= nib_co;
               idx_r   <= idx_r + 1'b1;
               if (last_nib) begin
                  sum  <= {nib_s, acc_r};
                  cout <= nib_co;
                  ovf  <= nib_c3 ^ nib_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_addsub16.sv
// Bench for cla_seq_addsub16: protocol model plus result scoreboard, directed
// arithmetic corners, ignored restarts, mid-operation reset and back-to-back random ops.
module tb_cla_seq_addsub16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   cla_seq_addsub16 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Golden result {cout, ovf, sum} from plain integer arithmetic.
   function automatic logic [17:0] golden(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
      logic [16:0] r;
      logic        v;
      if (s) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
      else   r = {1'b0, x} + {1'b0, y};
      if (s) v = (x[15] != y[15]) && (r[15] != x[15]);
      else   v = (x[15] == y[15]) && (r[15] != x[15]);
      return {r[16], v, r[15:0]};
   endfunction

   // Protocol model: 0 idle, 1..4 running, 5 done.
   logic [17:0] sb[$];
   int          mcnt = 0;
   logic [17:0] held = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 0;
         held <= '0;
         sb.delete();
      end else begin
         if (mcnt == 0) begin
            if (start) begin
               sb.push_back(golden(a, b, sub));
               mcnt <= 1;
            end
         end else if (mcnt == 4) begin
            mcnt <= 5;
            if (sb.size() == 0) held <= 18'h3FFFF;
            else                held <= sb.pop_front();
         end else if (mcnt == 5) begin
            mcnt <= 0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", busy, (mcnt != 0));
      check("done", done, (mcnt == 5));
      check("result", {cout, ovf, sum}, held);
   end

   task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic [15:0] es, input logic ec,
                         input logic eo);
      int lat;
      @(negedge clk);
      start = 1'b1; a = x; b = y; sub = s;
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = ~s;
      lat = 1;
      while (!done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 5);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
   endtask

   initial begin
      int ndone, last_cyc, cyc, lat;

      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", {cout, ovf, sum}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_1234", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub_brw",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      // Restart attempts while busy must be ignored.
      @(negedge clk);
      start = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("restart_ndone", ndone, 1);
      check("restart_sum", sum, 16'h3210);
      check("restart_cout", cout, 1);

      // Reset during RUN after the second nibble.
      @(negedge clk);
      start = 1'b1; a = 16'hABCD; b = 16'h1357; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_out", {cout, ovf, sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_nodone", ndone, 0);
      run_op("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

      // Back-to-back: start held high, operands scrambled every cycle.
      @(negedge clk);
      start = 1'b1;
      ndone = 0; last_cyc = 0; cyc = 0;
      while (ndone < 1000 && cyc < 7000) begin
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
         @(negedge clk);
         cyc++;
         if (done) begin
            if (ndone > 0) check("b2b_gap", cyc - last_cyc, 6);
            last_cyc = cyc;
            ndone++;
         end
      end
      check("b2b_count", ndone, 1000);
      start = 1'b0;
      lat = 0;
      while (busy && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla_seq_addsub16.md
CLA_SEQ_ADDSUB16 -- requirements
Module: cla_seq_addsub16

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port: sub  input  1  operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-005 SHALL have port: a  input  16  operand A, unsigned/two's-complement; sampled with start.
REQ-006 SHALL have port: b  input  16  operand B; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: sum  output  16  registered result.
REQ-010 SHALL have port: cout  output  1  carry out of bit 15 (for sub: 1 = no borrow).
REQ-011 SHALL have port: ovf  output  1  signed overflow = carry into bit 15 XOR carry out of bit 15.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after 4th nibble, DONE->IDLE unconditionally next cycle.
REQ-013 SHALL, on the edge accepting start (E0), latch a, b_eff = sub ? ~b : b, carry register = sub, nibble index = 0.
REQ-014 SHALL process one 4-bit nibble per cycle, index 0..3 on edges E1..E4, least significant first.
REQ-015 SHALL compute per nibble p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i, carries c1..c3 by two-level lookahead from carry register (no ripple chain).
REQ-016 SHALL form group P = p3&p2&p1&p0, group G = g3|p3g2|p3p2g1|p3p2p1g0, nibble carry out = G | P&cin, stored into carry register.
REQ-017 SHALL form nibble sum bits as p_i ^ c_i (c0 = carry register).
REQ-018 SHALL capture the carry into bit 15 (c3 of nibble 3) for overflow computation.
REQ-019 SHALL load sum, cout, ovf together on E4 only; hold them stable until the next completion or reset.
REQ-020 SHALL assert done exactly one cycle (state DONE, between E4 and E5); latency start edge to done = 4 cycles.
REQ-021 SHALL ignore start while in RUN or DONE; operand/sub changes after E0 SHALL NOT affect the result.
REQ-022 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back throughput one op per 6 cycles).
REQ-023 SHALL wrap modulo 2^16 with no saturation.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, sum=0x0000, cout=0, ovf=0, clear internal operand/carry/index registers.
REQ-025 SHALL abort any in-progress operation on reset with no done pulse; outputs remain at reset values until a fresh operation completes.
REQ-026 SHALL begin normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-027 add a=0x1234 b=0x0FFF -> done 4 cycles after start, sum=0x2233 cout=0 ovf=0.
REQ-028 add a=0xFFFF b=0x0001 -> sum=0x0000 cout=1 ovf=0; add a=0x7FFF b=0x0001 -> sum=0x8000 cout=0 ovf=1.
REQ-029 sub a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1; sub a=0x0000 b=0x0001 -> sum=0xFFFF cout=0 ovf=0.
REQ-030 start pulsed again on cycles 1-3 after acceptance with different operands -> ignored, exactly one done, result from first operands.
REQ-031 rst_n low during RUN (after E2) -> busy=0 immediately, no done, sum/cout/ovf = 0; next op 0x0005+0x0003 -> sum=0x0008.
REQ-032 back-to-back: start held high continuously -> done pulses every 6 cycles, each result matches a Python/SV golden model over 1000 random a, b, sub.
